// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: groups the tick/button inputs and the LED/rate outputs
// of the LED pattern controller.
//   i_tick     : 1-cycle step pulse from the tick generator
//   i_enable   : 1 = steps accepted, 0 = pattern frozen
//   i_mode     : 00 ring-left, 01 ring-right, 10 ping-pong, 11 blink-all
//   i_btn_next : 1-cycle debounced button pulse, steps o_sel
//   o_led      : LED drive, 1 = lit
//   o_sel      : rate select to the tick generator
//   o_wrap     : 1-cycle pulse when the pattern completes a cycle
// modport master drives the inputs (stimulus side), slave is the controller.
interface led_pattern_ctrl_if #(
  parameter int unsigned N_LEDS = 4
);
  logic              i_tick;
  logic              i_enable;
  logic [1:0]        i_mode;
  logic              i_btn_next;
  logic [N_LEDS-1:0] o_led;
  logic [1:0]        o_sel;
  logic              o_wrap;

  modport master (
    output i_tick, i_enable, i_mode, i_btn_next,
    input  o_led, o_sel, o_wrap
  );

  modport slave (
    input  i_tick, i_enable, i_mode, i_btn_next,
    output o_led, o_sel, o_wrap
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: advances a ring / ping-pong / blink LED pattern on each
// qualified tick (i_tick & i_enable) and owns the 2-bit rate select that a
// button pulse steps through.
// Ports:
//   clk     : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : led_pattern_ctrl_if.slave (tick, enable, mode, button in;
//             LED bank, rate select, wrap pulse out), all outputs registered
module led_pattern_ctrl #(
  parameter int unsigned N_LEDS = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  led_pattern_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RING_L,
    RING_R,
    PP_UP,
    PP_DN,
    BLINK_ON,
    BLINK_OFF
  } state_t;

  localparam logic [N_LEDS-1:0] LED_BOT = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] LED_TOP = {1'b1, {(N_LEDS-1){1'b0}}};

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [N_LEDS-1:0] led_q;
  logic [1:0]        sel_q;
  logic              wrap_q;

  logic              step;
  logic              mode_change;
  logic              led_onehot;
  logic [N_LEDS-1:0] rot_l;
  logic [N_LEDS-1:0] rot_r;
  state_t            reload_state;
  logic [N_LEDS-1:0] reload_led;

  assign step        = bus.i_tick & bus.i_enable;
  assign mode_change = (bus.i_mode != mode_q);
  assign led_onehot  = (led_q != '0) && ((led_q & (led_q - LED_BOT)) == '0);
  assign rot_l       = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
  assign rot_r       = {led_q[0], led_q[N_LEDS-1:1]};

  // Start state and pattern entered when a step sees a new mode.
  always_comb begin
    reload_state = RING_L;
    reload_led   = LED_BOT;
    case (bus.i_mode)
      2'b00: begin
        reload_state = RING_L;
        reload_led   = LED_BOT;
      end
      2'b01: begin
        reload_state = RING_R;
        reload_led   = LED_TOP;
      end
      2'b10: begin
        reload_state = PP_UP;
        reload_led   = LED_BOT;
      end
      default: begin
        reload_state = BLINK_ON;
        reload_led   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RING_L;
      mode_q  <= '0;
      led_q   <= LED_BOT;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;

      if (bus.i_btn_next) begin
        sel_q <= sel_q + 2'd1;
      end

      if (step) begin
        if (mode_change) begin
          mode_q  <= bus.i_mode;
          state_q <= reload_state;
          led_q   <= reload_led;
        end else begin
          case (state_q)
            RING_L: begin
              if (!led_onehot) begin
                led_q <= LED_BOT;
              end else begin
                led_q  <= rot_l;
                wrap_q <= led_q[N_LEDS-1];
              end
            end
            RING_R: begin
              if (!led_onehot) begin
                led_q <= LED_BOT;
              end else begin
                led_q  <= rot_r;
                wrap_q <= led_q[0];
              end
            end
            // Direction flips on the step that lands on an endpoint, so the
            // endpoint is shown once and the next step already moves back.
            PP_UP: begin
              if (!led_onehot || led_q[N_LEDS-1]) begin
                led_q <= LED_BOT;
              end else begin
                led_q <= led_q << 1;
                if (led_q[N_LEDS-2]) begin
                  state_q <= PP_DN;
                end
              end
            end
            PP_DN: begin
              if (!led_onehot || led_q[0]) begin
                led_q   <= LED_BOT;
                state_q <= PP_UP;
              end else begin
                led_q <= led_q >> 1;
                if (led_q[1]) begin
                  state_q <= PP_UP;
                  wrap_q  <= 1'b1;
                end
              end
            end
            BLINK_ON: begin
              led_q   <= '0;
              state_q <= BLINK_OFF;
            end
            BLINK_OFF: begin
              led_q   <= '1;
              state_q <= BLINK_ON;
              wrap_q  <= 1'b1;
            end
            default: begin
              led_q   <= LED_BOT;
              state_q <= RING_L;
            end
          endcase
        end
      end
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_sel  = sel_q;
  assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] led;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];

  led_pattern_ctrl_if #(.N_LEDS(4)) bus ();

  led_pattern_ctrl #(.N_LEDS(4)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drive one tick pulse (optionally with a button pulse) for one cycle and
  // queue the expected post-step output. Returns on the negedge after the
  // capturing posedge.
  task automatic drive_tick(input logic [3:0] el, input logic ew, input logic btn);
    @(negedge clk);
    bus.i_tick     = 1'b1;
    bus.i_btn_next = btn;
    sbq.push_back('{el, ew});
    @(negedge clk);
    bus.i_tick     = 1'b0;
    bus.i_btn_next = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.i_tick     = 1'b0;
    bus.i_enable   = 1'b1;
    bus.i_mode     = 2'b00;
    bus.i_btn_next = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_led !== 4'b0001 || bus.o_sel !== 2'b00 || bus.o_wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got led=%b sel=%b wrap=%b want led=0001 sel=00 wrap=0",
               bus.o_led, bus.o_sel, bus.o_wrap);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_led !== 4'b0001 || bus.o_sel !== 2'b00 || bus.o_wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got led=%b sel=%b wrap=%b want led=0001 sel=00 wrap=0",
               bus.o_led, bus.o_sel, bus.o_wrap);
    end
  endtask

  task automatic test_ring_left();
    logic [3:0] seq [5];
    logic       wr  [5];
    exp_t       e;
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.i_mode   = 2'b00;
    bus.i_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_tick(seq[i], wr[i], 1'b0);
      e = sbq.pop_front();
      total++;
      if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
        bad++;
        $display("FAIL ring_l_step[%0d]: got led=%b wrap=%b want led=%b wrap=%b",
                 i, bus.o_led, bus.o_wrap, e.led, e.wrap);
      end
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        total++;
        if (bus.o_led !== e.led || bus.o_wrap !== 1'b0) begin
          bad++;
          $display("FAIL ring_l_gap[%0d.%0d]: got led=%b wrap=%b want led=%b wrap=0",
                   i, c, bus.o_led, bus.o_wrap, e.led);
        end
      end
    end
  endtask

  task automatic test_ping_pong();
    logic [3:0] seq [9];
    logic       wr  [9];
    exp_t       e;
    // First step reloads to 0001 on the mode change, then the 8-step run.
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
            4'b0010, 4'b0001, 4'b0010, 4'b0100};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.i_mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      drive_tick(seq[i], wr[i], 1'b0);
      e = sbq.pop_front();
      total++;
      if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
        bad++;
        $display("FAIL pp_step[%0d]: got led=%b wrap=%b want led=%b wrap=%b",
                 i, bus.o_led, bus.o_wrap, e.led, e.wrap);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++;
        if (bus.o_led !== e.led || bus.o_wrap !== 1'b0) begin
          bad++;
          $display("FAIL pp_gap[%0d.%0d]: got led=%b wrap=%b want led=%b wrap=0",
                   i, c, bus.o_led, bus.o_wrap, e.led);
        end
      end
    end
  endtask

  task automatic test_mode_change();
    logic [3:0] seq [6];
    logic       wr  [6];
    exp_t       e;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b0000, 4'b1111};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.i_mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive_tick(seq[i], wr[i], 1'b0);
      e = sbq.pop_front();
      total++;
      if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
        bad++;
        $display("FAIL mode_step[%0d]: got led=%b wrap=%b want led=%b wrap=%b",
                 i, bus.o_led, bus.o_wrap, e.led, e.wrap);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        // Mode switched mid-gap; it must not touch the LEDs until a step.
        if (i == 2 && c == 1) bus.i_mode = 2'b11;
        total++;
        if (bus.o_led !== e.led || bus.o_wrap !== 1'b0) begin
          bad++;
          $display("FAIL mode_gap[%0d.%0d]: got led=%b wrap=%b want led=%b wrap=0",
                   i, c, bus.o_led, bus.o_wrap, e.led);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] seq [7];
    logic       wr  [7];
    exp_t       e;
    // Two steps to 0010 in ring-left, four frozen ticks, then one live step.
    seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.i_mode = 2'b00;
    for (int i = 0; i < 7; i++) begin
      bus.i_enable = (i >= 2 && i <= 5) ? 1'b0 : 1'b1;
      drive_tick(seq[i], wr[i], 1'b0);
      e = sbq.pop_front();
      total++;
      if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
        bad++;
        $display("FAIL enable_step[%0d]: got led=%b wrap=%b want led=%b wrap=%b",
                 i, bus.o_led, bus.o_wrap, e.led, e.wrap);
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        total++;
        if (bus.o_led !== e.led || bus.o_wrap !== 1'b0) begin
          bad++;
          $display("FAIL enable_gap[%0d.%0d]: got led=%b wrap=%b want led=%b wrap=0",
                   i, c, bus.o_led, bus.o_wrap, e.led);
        end
      end
    end
    bus.i_enable = 1'b1;
  endtask

  task automatic test_sel_step();
    logic [1:0] sel_exp [5];
    logic [3:0] led_exp;
    exp_t       e;
    sel_exp = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    led_exp = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        drive_tick(4'b1000, 1'b0, 1'b1);
        e = sbq.pop_front();
        led_exp = e.led;
        total++;
        if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
          bad++;
          $display("FAIL sel_coincident_led: got led=%b wrap=%b want led=%b wrap=%b",
                   bus.o_led, bus.o_wrap, e.led, e.wrap);
        end
      end else begin
        @(negedge clk);
        bus.i_btn_next = 1'b1;
        @(negedge clk);
        bus.i_btn_next = 1'b0;
      end
      total++;
      if (bus.o_sel !== sel_exp[i]) begin
        bad++;
        $display("FAIL sel_step[%0d]: got sel=%b want sel=%b", i, bus.o_sel, sel_exp[i]);
      end
      @(negedge clk);
      total++;
      if (bus.o_sel !== sel_exp[i] || bus.o_led !== led_exp) begin
        bad++;
        $display("FAIL sel_hold[%0d]: got sel=%b led=%b want sel=%b led=%b",
                 i, bus.o_sel, bus.o_led, sel_exp[i], led_exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] seq [5];
    exp_t       e;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    bus.i_mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      drive_tick(seq[i], 1'b0, 1'b0);
      e = sbq.pop_front();
      total++;
      if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
        bad++;
        $display("FAIL areset_pre[%0d]: got led=%b wrap=%b want led=%b wrap=%b",
                 i, bus.o_led, bus.o_wrap, e.led, e.wrap);
      end
    end
    // Now in PP_DN at 0100 with o_sel=01; assert reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_led !== 4'b0001 || bus.o_sel !== 2'b00 || bus.o_wrap !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate: got led=%b sel=%b wrap=%b want led=0001 sel=00 wrap=0",
               bus.o_led, bus.o_sel, bus.o_wrap);
    end
    @(negedge clk);
    bus.i_mode = 2'b00;
    rst_n      = 1'b1;
    drive_tick(4'b0010, 1'b0, 1'b0);
    e = sbq.pop_front();
    total++;
    if (bus.o_led !== e.led || bus.o_wrap !== e.wrap) begin
      bad++;
      $display("FAIL areset_first_step: got led=%b wrap=%b want led=%b wrap=%b",
               bus.o_led, bus.o_wrap, e.led, e.wrap);
    end
  endtask

  initial begin
    test_reset();
    test_ring_left();
    test_ping_pong();
    test_mode_change();
    test_enable();
    test_sel_step();
    test_async_reset();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Consumer of the blink-rate tick generator. It advances a one-hot or blink LED pattern on each qualified 1-cycle tick pulse and drives the LED bank. It also owns the speed-select register that feeds the tick generator's 2-bit rate input, which a pushbutton pulse steps through. It sits between the tick generator and the board LED pins.

Parameters:
N_LEDS, 4, LED bank width; legal range 2 to 32.

Ports:
clk  in  1  system clock; single clock domain.
i_rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
i_tick  in  1  1-cycle pulse from the tick generator's valid output; one pattern step per pulse.
i_enable  in  1  1 = ticks accepted; 0 = pattern frozen; o_sel stepping still works.
i_mode  in  2  00 ring-left, 01 ring-right, 10 ping-pong, 11 blink-all.
i_btn_next  in  1  1-cycle pulse from a debounced button; steps o_sel.
o_led  out  N_LEDS  registered LED drive; 1 = lit.
o_sel  out  2  registered rate select to the tick generator: 00 1000 ms, 01 500 ms, 10 250 ms, 11 100 ms.
o_wrap  out  1  1-cycle pulse when the pattern completes a cycle.

Behaviour:
- Reset (async assert, sync release) sets o_led=1 (bit0), o_sel=00, o_wrap=0, FSM=RING_L, and the stored mode register to 00.
- A step is qualified when i_tick=1 and i_enable=1. Only qualified steps change o_led. o_led and o_wrap update on the clock edge that samples the qualified tick, so they are valid the next cycle (latency 1).
- o_wrap defaults to 0 every cycle. It is never asserted without a qualified step.
- On a qualified step where i_mode differs from the stored mode:
  - Store the new mode and reload the start pattern.
  - Start patterns: RING_L or PP_UP → 1; RING_R → 1<<(N_LEDS-1); BLINK_ON → all ones.
  - o_wrap=0 on this step.
- FSM states: RING_L, RING_R, PP_UP, PP_DN, BLINK_ON, BLINK_OFF. On a qualified step with unchanged mode:
  - RING_L: rotate left. When bit N-1 wraps to bit0, pulse o_wrap.
  - RING_R: rotate right. When bit0 wraps to bit N-1, pulse o_wrap.
  - PP_UP: shift left. On reaching bit N-1, go to PP_DN.
  - PP_DN: shift right. On reaching bit0, go to PP_UP and pulse o_wrap.
  - Ping-pong never dwells twice on an endpoint. N=4 sequence: 0001,0010,0100,1000,0100,0010,0001,0010...
  - N_LEDS=2 ping-pong sequence: 01,10,01, with a wrap on each 01.
  - BLINK_ON → BLINK_OFF: o_led=0.
  - BLINK_OFF → BLINK_ON: o_led=all ones, pulse o_wrap.
- i_mode changes between qualified steps have no effect until the next qualified step. i_mode is sampled only on qualified steps.
- i_enable=0: o_led and FSM hold indefinitely. Re-enable resumes from the held state without a reload.
- i_btn_next=1: o_sel <= o_sel+1, mod 4; 11 wraps to 00. Independent of i_enable and i_tick.
- If i_btn_next and a qualified tick occur in the same cycle, both take effect in that cycle.
- The pattern is not reset by an o_sel change.
- o_led is always one-hot in ring and ping-pong modes. Any non-one-hot value reached in those modes (e.g. after a mode reload glitch) is corrected to 1 on the next qualified step.
- Reset asserted mid-pattern returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset release, mode=00, enable=1, 5 ticks 10 cycles apart → o_led 0010,0100,1000,0001,0010; o_wrap high exactly 1 cycle with the 0001 update.
2. mode=10, 8 ticks from 0001 → o_led 0010,0100,1000,0100,0010,0001,0010,0100; single o_wrap at 0001.
3. Mode 00 at o_led=0100, change i_mode to 11 mid-gap, then 3 ticks → 1111 (reload, no wrap), 0000, 1111 with o_wrap.
4. enable=0 with 4 ticks → o_led unchanged, o_wrap never high; enable=1 then 1 tick → advances one step from the held value.
5. 5 i_btn_next pulses, one coinciding with a tick → o_sel 01,10,11,00,01; the coincident tick still advances o_led.
6. Assert i_rst_n low between clock edges mid ping-pong (PP_DN at 0100) → o_led=0001 and o_sel=00 before the next edge; first tick after release gives 0010.
